// File: rtl/reloj_pkg.sv
// Shared digit widths, hour constants and BCD validity helpers for the clock stages.
package reloj_pkg;

    localparam int DEC_W = 2;
    localparam int UNI_W = 4;

    typedef struct packed {
        logic [DEC_W-1:0] dec;
        logic [UNI_W-1:0] uni;
    } hora_t;

    localparam hora_t HORA_CERO   = '{dec: 2'd0, uni: 4'd0};
    localparam hora_t HORA_MAX_24 = '{dec: 2'd2, uni: 4'd3};
    localparam hora_t HORA_MAX_12 = '{dec: 2'd1, uni: 4'd2};
    localparam hora_t HORA_MIN_12 = '{dec: 2'd0, uni: 4'd1};

    function automatic logic es_valida_24(hora_t h);
        return (h.uni <= 4'd9) && ((h.dec < 2'd2) || ((h.dec == 2'd2) && (h.uni <= 4'd3)));
    endfunction

    function automatic logic es_valida_12(hora_t h);
        return ((h.dec == 2'd0) && (h.uni >= 4'd1) && (h.uni <= 4'd9)) ||
               ((h.dec == 2'd1) && (h.uni <= 4'd2));
    endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Multi-stage synchronizer for an asynchronous input plus a one-cycle rising-edge pulse.
module sincronizador_flanco #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic nivel,
    output logic flanco
);

    logic [STAGES-1:0] sync_pipe;
    logic              nivel_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
            nivel_q   <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[STAGES-2:0], din};
            nivel_q   <= sync_pipe[STAGES-1];
        end
    end

    assign nivel  = sync_pipe[STAGES-1];
    assign flanco = nivel & ~nivel_q;

endmodule

// File: rtl/contador_horas.sv
// Hours stage: BCD hour counter stepped by the minutes carry or the adjust button (with auto-repeat).
// Define FORMATO_12H_EN for the 12-hour build with AM/PM flag.
module contador_horas
    import reloj_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_CYCLES = 50_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             modifHor,
    input  logic             ajusteHor,
    output logic [DEC_W-1:0] decenas,
    output logic [UNI_W-1:0] unidades,
    output logic             pm,
    output logic             modifDia
);

    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic  modifHor_q;
    logic  inc_carry, inc_adj, rep_fire, paso;
    logic  adj_nivel, adj_flanco;
    hora_t hora, hora_sig;
    logic  dia_sig;

    sincronizador_flanco #(.STAGES(SYNC_STAGES)) u_sync_adj (
        .clock  (clock),
        .reset  (reset),
        .din    (ajusteHor),
        .nivel  (adj_nivel),
        .flanco (adj_flanco)
    );

    // Reset value of 1 keeps a carry already high at reset release from stepping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) modifHor_q <= 1'b1;
        else       modifHor_q <= modifHor;
    end

    assign inc_carry = modifHor & ~modifHor_q;
    assign inc_adj   = adj_flanco;

    generate
        if (REPEAT_CYCLES > 0) begin : g_rep
            logic [REP_W-1:0] rep_cnt;

            // Counts cycles since the last adjust step; restarts on each step and on release.
            always_ff @(posedge clock or posedge reset) begin
                if (reset)                                   rep_cnt <= '0;
                else if (!adj_nivel || adj_flanco || rep_fire) rep_cnt <= '0;
                else                                         rep_cnt <= rep_cnt + 1'b1;
            end

            assign rep_fire = adj_nivel & ~adj_flanco & (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end
    endgenerate

    assign paso = inc_carry | inc_adj | rep_fire;

`ifdef FORMATO_12H_EN
    localparam hora_t HORA_11 = '{dec: 2'd1, uni: 4'd1};
    logic pm_q, pm_sig;

    always_comb begin
        hora_sig = hora;
        pm_sig   = pm_q;
        dia_sig  = 1'b0;
        if (paso) begin
            if (!es_valida_12(hora)) begin
                hora_sig = HORA_MAX_12;
            end else if (hora == HORA_MAX_12) begin
                hora_sig = HORA_MIN_12;
            end else if (hora.uni == 4'd9) begin
                hora_sig.dec = hora.dec + 1'b1;
                hora_sig.uni = '0;
            end else begin
                hora_sig.uni = hora.uni + 1'b1;
                // 11 -> 12 flips the meridiem; PM 11 -> AM 12 closes the day.
                if (hora == HORA_11) begin
                    pm_sig  = ~pm_q;
                    dia_sig = inc_carry & pm_q;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hora     <= HORA_MAX_12;
            pm_q     <= 1'b0;
            modifDia <= 1'b0;
        end else begin
            hora     <= hora_sig;
            pm_q     <= pm_sig;
            modifDia <= dia_sig;
        end
    end

    assign pm = pm_q;
`else
    always_comb begin
        hora_sig = hora;
        dia_sig  = 1'b0;
        if (paso) begin
            if (!es_valida_24(hora)) begin
                hora_sig = HORA_CERO;
            end else if (hora == HORA_MAX_24) begin
                hora_sig = HORA_CERO;
                dia_sig  = inc_carry;
            end else if (hora.uni == 4'd9) begin
                hora_sig.dec = hora.dec + 1'b1;
                hora_sig.uni = '0;
            end else begin
                hora_sig.uni = hora.uni + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hora     <= HORA_CERO;
            modifDia <= 1'b0;
        end else begin
            hora     <= hora_sig;
            modifDia <= dia_sig;
        end
    end

    assign pm = 1'b0;
`endif

    assign decenas  = hora.dec;
    assign unidades = hora.uni;

endmodule

// File: tb/tb_contador_horas.sv
// Directed bench for contador_horas; hour values are compared as two-digit BCD (8'h17 = 17).
module tb_contador_horas;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       modifHor = 1'b0;
    logic       ajusteHor = 1'b0;
    logic [1:0] decenas;
    logic [3:0] unidades;
    logic       pm;
    logic       modifDia;

    int n_cmp = 0;
    int n_err = 0;
    int dia_cnt = 0;
    int d0;
    logic last_dia;

    contador_horas #(.SYNC_STAGES(2), .REPEAT_CYCLES(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .modifHor  (modifHor),
        .ajusteHor (ajusteHor),
        .decenas   (decenas),
        .unidades  (unidades),
        .pm        (pm),
        .modifDia  (modifDia)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        if (modifDia) dia_cnt++;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hh();
        return {26'b0, decenas, unidades};
    endfunction

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulso();
        modifHor = 1'b1;
        @(negedge clock);
        last_dia = modifDia;
        modifHor = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulsos(input int n);
        for (int i = 0; i < n; i++) pulso();
    endtask

    task automatic reinicio();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        ciclos(2);
`ifdef FORMATO_12H_EN
        comprobar("rst12_hora", hh(), 32'h12);
        comprobar("rst12_pm", {31'b0, pm}, 32'd0);
        reset = 1'b0;
        ciclos(3);
        comprobar("idle12", hh(), 32'h12);
        pulsos(11);
        comprobar("am11", hh(), 32'h11);
        comprobar("am11_pm", {31'b0, pm}, 32'd0);
        d0 = dia_cnt;
        pulso();
        comprobar("pm12", hh(), 32'h12);
        comprobar("pm12_pm", {31'b0, pm}, 32'd1);
        comprobar("pm12_nodia", dia_cnt, d0);
        pulso();
        comprobar("pm01", hh(), 32'h01);
        pulsos(10);
        comprobar("pm11", hh(), 32'h11);
        comprobar("pm11_pm", {31'b0, pm}, 32'd1);
        pulso();
        comprobar("am12", hh(), 32'h12);
        comprobar("am12_pm", {31'b0, pm}, 32'd0);
        comprobar("am12_dia", {31'b0, last_dia}, 32'd1);
        comprobar("am12_dia_cnt", dia_cnt, d0 + 1);
        pulsos(3);
        comprobar("am03", hh(), 32'h03);
        #2 reset = 1'b1;
        #1;
        comprobar("rst12_async", hh(), 32'h12);
        comprobar("rst12_async_pm", {31'b0, pm}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ciclos(2);
        comprobar("rst12_hold", hh(), 32'h12);
`else
        // Reset state and asynchronous reset mid-count.
        comprobar("rst_hora", hh(), 32'h00);
        comprobar("rst_dia", {31'b0, modifDia}, 32'd0);
        reset = 1'b0;
        ciclos(3);
        comprobar("idle", hh(), 32'h00);
        pulsos(17);
        comprobar("cuenta17", hh(), 32'h17);
        #2 reset = 1'b1;
        #1;
        comprobar("rst_async_hora", hh(), 32'h00);
        comprobar("rst_async_pm", {31'b0, pm}, 32'd0);
        comprobar("rst_async_dia", {31'b0, modifDia}, 32'd0);
        modifHor = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ciclos(5);
        comprobar("carry_alto_release", hh(), 32'h00);
        modifHor = 1'b0;
        ciclos(4);
        comprobar("sin_paso", hh(), 32'h00);

        // Long carry level gives one step.
        pulsos(5);
        comprobar("cuenta05", hh(), 32'h05);
        modifHor = 1'b1;
        ciclos(1000);
        modifHor = 1'b0;
        ciclos(2);
        comprobar("carry_largo", hh(), 32'h06);

        // Full day of carries, rollover pulse only on 23 -> 00.
        reinicio();
        d0 = dia_cnt;
        pulsos(23);
        comprobar("cuenta23", hh(), 32'h23);
        comprobar("sin_dia_antes", dia_cnt, d0);
        pulso();
        comprobar("vuelta00", hh(), 32'h00);
        comprobar("dia_pulso", {31'b0, last_dia}, 32'd1);
        comprobar("dia_un_ciclo", dia_cnt, d0 + 1);
        comprobar("dia_bajo", {31'b0, modifDia}, 32'd0);
        comprobar("pm_cero", {31'b0, pm}, 32'd0);

        // Adjust tap latency and auto-repeat.
        pulsos(9);
        comprobar("cuenta09", hh(), 32'h09);
        ajusteHor = 1'b1;
        ciclos(2);
        comprobar("ajuste_lat2", hh(), 32'h09);
        ciclos(1);
        comprobar("ajuste_lat3", hh(), 32'h10);
        ajusteHor = 1'b0;
        ciclos(12);
        comprobar("toque_sin_repeticion", hh(), 32'h10);
        ajusteHor = 1'b1;
        ciclos(40);
        ajusteHor = 1'b0;
        ciclos(12);
        comprobar("repeticion", hh(), 32'h15);

        // Coalesced carry and adjust edges.
        reinicio();
        pulsos(11);
        comprobar("cuenta11", hh(), 32'h11);
        d0 = dia_cnt;
        ajusteHor = 1'b1;
        ciclos(2);
        modifHor = 1'b1;
        ciclos(1);
        comprobar("coalesce", hh(), 32'h12);
        ciclos(3);
        ajusteHor = 1'b0;
        modifHor = 1'b0;
        ciclos(10);
        comprobar("coalesce_hold", hh(), 32'h12);

        // Adjust-driven wrap does not signal a new day.
        reinicio();
        pulsos(23);
        d0 = dia_cnt;
        ajusteHor = 1'b1;
        ciclos(3);
        ajusteHor = 1'b0;
        ciclos(10);
        comprobar("ajuste_vuelta", hh(), 32'h00);
        comprobar("ajuste_sin_dia", dia_cnt, d0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
